// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. Captures digits, decimal points and blank mask into a
// shadow register on load, then scans one digit per slot with an all-off
// guard interval at the start of each slot, optional leading-zero blanking
// and a one-cycle frame strobe per completed scan.
module hex_display_scanner #(
  parameter int REFRESH_COUNT = 131072,
  parameter int GUARD_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  input  logic        lead_zero_blank,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  an_out,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_COUNT - 1);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYCLES);

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [15:0]      dig_sh;
  logic [3:0]       dp_sh;
  logic [3:0]       mask_sh;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             slot_last;

  logic [3:0]       nib_p0;
  logic [3:0]       lz_p0;
  logic             blank_p0;
  logic             guard_p0;

  // Snapshot register: display logic never sees the live inputs directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_sh  <= '0;
      dp_sh   <= '0;
      mask_sh <= '0;
    end else if (load) begin
      dig_sh  <= digits_in;
      dp_sh   <= dp_in;
      mask_sh <= blank_mask;
    end
  end

  assign slot_last = (cnt == CNT_LAST);

  // Slot counter and digit index; frame strobe follows the 3->0 index wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      if (slot_last) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      frame_tick <= slot_last && (idx == 2'd3);
    end
  end

  // ---- stage p0: select current digit and decide whether it is dark ----
  // lz_p0[i] is set when digit i and every digit to its left are zero;
  // digit 0 is exempt so a zero value still shows a single '0'.
  always_comb begin
    nib_p0   = dig_sh[{idx, 2'b00} +: 4];
    lz_p0    = 4'b0000;
    lz_p0[3] = (dig_sh[15:12] == 4'h0);
    lz_p0[2] = lz_p0[3] && (dig_sh[11:8] == 4'h0);
    lz_p0[1] = lz_p0[2] && (dig_sh[7:4] == 4'h0);
    lz_p0[0] = 1'b0;
    guard_p0 = (cnt < GUARD_LIM);
    blank_p0 = mask_sh[idx] || (lead_zero_blank && lz_p0[idx]);
  end

  // ---- stage p1: registered display outputs ----
  // Anodes stay off during the guard interval so the previous digit's
  // segment pattern never ghosts onto the newly selected digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_out  <= 4'b1111;
      seg_out <= 7'h7F;
      dp_out  <= 1'b1;
    end else if (guard_p0 || blank_p0) begin
      an_out  <= 4'b1111;
      seg_out <= 7'h7F;
      dp_out  <= 1'b1;
    end else begin
      an_out  <= ~(4'b0001 << idx);
      seg_out <= hex_to_seg(nib_p0);
      dp_out  <= ~dp_sh[idx];
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Testbench for hex_display_scanner with a short refresh period.
module tb_hex_display_scanner;

  localparam int RC    = 8;
  localparam int GC    = 2;
  localparam int FRAME = 4 * RC;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lead_zero_blank;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  hex_display_scanner #(.REFRESH_COUNT(RC), .GUARD_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .lead_zero_blank(lead_zero_blank),
    .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpv;
    logic [3:0]  mask;
    logic        lz;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  localparam out_t DARK = '{an: 4'b1111, seg: 7'h7F, dp: 1'b1};

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: edges elapsed since reset release plus the snapshot.
  int          m_edges;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  m_mask;
  out_t        e_out;
  logic        e_ft;

  int n_tests;
  int n_fail;

  vec_t tbl [17];

  // What the display should show for a given elapsed time and snapshot.
  function automatic out_t model_out(int t, logic [15:0] dig, logic [3:0] dpv,
                                     logic [3:0] mask, logic lz);
    int   i;
    int   c;
    int   nib;
    bit   blank;
    out_t o;
    i     = (t / RC) % 4;
    c     = t % RC;
    nib   = int'((dig >> (4 * i)) & 16'h000F);
    blank = mask[i] || (lz && i >= 1 && (dig >> (4 * i)) == 16'h0000);
    o     = DARK;
    if (c >= GC && !blank) begin
      o.an  = 4'b1111 ^ (4'b0001 << i);
      o.seg = seg_tab[nib];
      o.dp  = ~dpv[i];
    end
    return o;
  endfunction

  // Model update: outputs after an edge reflect the state before it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges <= 0;
      m_dig   <= '0;
      m_dp    <= '0;
      m_mask  <= '0;
      e_out   <= DARK;
      e_ft    <= 1'b0;
    end else begin
      e_out <= model_out(m_edges, m_dig, m_dp, m_mask, lead_zero_blank);
      e_ft  <= ((m_edges % FRAME) == FRAME - 1);
      if (load) begin
        m_dig  <= digits_in;
        m_dp   <= dp_in;
        m_mask <= blank_mask;
      end
      m_edges <= m_edges + 1;
    end
  end

  // Advance to the next falling edge and compare every output with the model.
  task automatic step();
    @(negedge clk);
    n_tests++;
    if ({an_out, seg_out, dp_out, frame_tick} !== {e_out, e_ft}) begin
      n_fail++;
      $display("FAIL scoreboard t=%0d: got an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h dp=%b ft=%b",
               m_edges, an_out, seg_out, dp_out, frame_tick, e_out.an, e_out.seg, e_out.dp, e_ft);
    end
  endtask

  task automatic chk(input string name, input logic [3:0] an_e, input logic [6:0] seg_e,
                     input logic dp_e);
    n_tests++;
    if (an_out !== an_e || seg_out !== seg_e || dp_out !== dp_e) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
               name, an_out, seg_out, dp_out, an_e, seg_e, dp_e);
    end
  endtask

  // Step until the outputs show cnt=4 of the given slot (bounded).
  task automatic wait_slot(input int slot, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      if ((m_edges % FRAME) == slot * RC + 5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_slot%0d: slot never reached, got t=%0d", slot, m_edges);
    end
  endtask

  task automatic wait_edges(input int target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      if ((m_edges % FRAME) == target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_pos%0d: position never reached, got t=%0d", target, m_edges);
    end
  endtask

  initial begin
    bit ok;
    int ft_count;
    n_tests = 0;
    n_fail  = 0;

    tbl[0]  = '{16'hA5C3, 4'b0100, 4'b0000, 1'b0, 0, 4'b1110, 7'h30, 1'b1};
    tbl[1]  = '{16'hA5C3, 4'b0100, 4'b0000, 1'b0, 1, 4'b1101, 7'h46, 1'b1};
    tbl[2]  = '{16'hA5C3, 4'b0100, 4'b0000, 1'b0, 2, 4'b1011, 7'h12, 1'b0};
    tbl[3]  = '{16'hA5C3, 4'b0100, 4'b0000, 1'b0, 3, 4'b0111, 7'h08, 1'b1};
    tbl[4]  = '{16'h0005, 4'b0000, 4'b0000, 1'b1, 0, 4'b1110, 7'h12, 1'b1};
    tbl[5]  = '{16'h0005, 4'b0000, 4'b0000, 1'b1, 1, 4'b1111, 7'h7F, 1'b1};
    tbl[6]  = '{16'h0005, 4'b0000, 4'b0000, 1'b1, 2, 4'b1111, 7'h7F, 1'b1};
    tbl[7]  = '{16'h0005, 4'b0000, 4'b0000, 1'b1, 3, 4'b1111, 7'h7F, 1'b1};
    tbl[8]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
    tbl[9]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 2, 4'b1111, 7'h7F, 1'b1};
    tbl[10] = '{16'h0105, 4'b0000, 4'b0000, 1'b1, 1, 4'b1101, 7'h40, 1'b1};
    tbl[11] = '{16'h0105, 4'b0000, 4'b0000, 1'b1, 2, 4'b1011, 7'h79, 1'b1};
    tbl[12] = '{16'h0105, 4'b0000, 4'b0000, 1'b1, 3, 4'b1111, 7'h7F, 1'b1};
    tbl[13] = '{16'h1234, 4'b0000, 4'b0001, 1'b0, 0, 4'b1111, 7'h7F, 1'b1};
    tbl[14] = '{16'h1234, 4'b0000, 4'b0001, 1'b0, 1, 4'b1101, 7'h30, 1'b1};
    tbl[15] = '{16'h1234, 4'b0000, 4'b0001, 1'b0, 2, 4'b1011, 7'h24, 1'b1};
    tbl[16] = '{16'h1234, 4'b0000, 4'b0001, 1'b0, 3, 4'b0111, 7'h79, 1'b1};

    rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blank_mask = '0;
    lead_zero_blank = 1'b0;

    // Reset state, then first slot: two guard cycles, then digit 0 shows '0'.
    step();
    step();
    chk("reset_hold", 4'b1111, 7'h7F, 1'b1);
    rst = 1'b0;
    step(); chk("guard_c0", 4'b1111, 7'h7F, 1'b1);
    step(); chk("guard_c1", 4'b1111, 7'h7F, 1'b1);
    step(); chk("slot0_on", 4'b1110, 7'h40, 1'b1);

    // Table-driven slot checks.
    foreach (tbl[r]) begin
      digits_in = tbl[r].dig; dp_in = tbl[r].dpv; blank_mask = tbl[r].mask;
      lead_zero_blank = tbl[r].lz; load = 1'b1;
      step();
      load = 1'b0;
      step();
      wait_slot(tbl[r].slot, ok);
      if (ok) chk($sformatf("row%0d", r), tbl[r].an, tbl[r].seg, tbl[r].dpo);
    end

    // Two full frames must contain exactly two frame strobes.
    ft_count = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      if (frame_tick === 1'b1) ft_count++;
    end
    n_tests++;
    if (ft_count != 2) begin
      n_fail++;
      $display("FAIL frame_count: got %0d, want 2", ft_count);
    end

    // Mid-slot load: digit1 3 -> F while slot 1 is lit.
    digits_in = 16'h1234; dp_in = 4'b0000; blank_mask = 4'b0000; lead_zero_blank = 1'b0;
    load = 1'b1;
    step();
    load = 1'b0;
    wait_edges(RC + 5, ok);
    if (ok) begin
      digits_in = 16'h12F4;
      load = 1'b1;
      step();
      load = 1'b0;
      chk("midload_old", 4'b1101, 7'h30, 1'b1);
      step();
      chk("midload_new", 4'b1101, 7'h0E, 1'b1);
    end

    // Asynchronous reset mid-slot (idx=2, cnt=4), then restart from slot 0.
    wait_edges(2 * RC + 4, ok);
    if (ok) begin
      rst = 1'b1;
      #1;
      chk("rst_async", 4'b1111, 7'h7F, 1'b1);
      n_tests++;
      if (frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_ft: got %b, want 0", frame_tick);
      end
      step();
      rst = 1'b0;
      step(); chk("rst_guard0", 4'b1111, 7'h7F, 1'b1);
      step(); chk("rst_guard1", 4'b1111, 7'h7F, 1'b1);
      step(); chk("rst_cleared", 4'b1110, 7'h40, 1'b1);
    end

    // Randomized traffic against the model, including occasional resets.
    for (int k = 0; k < 1500; k++) begin
      step();
      digits_in       = 16'($urandom);
      dp_in           = 4'($urandom);
      blank_mask      = (($urandom % 3) == 0) ? 4'($urandom) : 4'b0000;
      lead_zero_blank = 1'($urandom);
      if (($urandom % 3) == 0) digits_in = digits_in & 16'h00FF;
      load            = (($urandom % 5) == 0);
      rst             = (($urandom % 300) == 0);
    end
    rst  = 1'b0;
    load = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
